// File: rtl/bar_leds_pwm.sv
// bar_leds_pwm: bus-mapped multi-channel LED driver with PWM brightness.
// Double-buffered duty registers, control/status registers, prescaled counter.
module bar_leds_pwm #(
    parameter int CHANNELS = 8,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int PWM_W    = 8,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic                ce_l,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   addr,
    inout  wire  [DATA_W:1]     data,
    output logic [CHANNELS:1]   leds
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(CHANNELS);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(CHANNELS + 1);

    logic              ce_s1, ce_s2, ce_s3;
    logic              rw_s1, rw_s2;
    logic              commit;
    logic              ctrl_wr;
    logic [PWM_W-1:0]  wdata;

    logic [PS_W-1:0]   pre;
    logic [PWM_W-1:0]  cnt;
    logic              tick;
    logic              wrap;

    logic [PWM_W-1:0]  shadow [CHANNELS];
    logic [PWM_W-1:0]  active [CHANNELS];
    logic              enable;
    logic              invert;
    logic              force_q;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            ce_s1 <= 1'b1;
            ce_s2 <= 1'b1;
            ce_s3 <= 1'b1;
            rw_s1 <= 1'b1;
            rw_s2 <= 1'b1;
        end else begin
            ce_s1 <= ce_l;
            ce_s2 <= ce_s1;
            ce_s3 <= ce_s2;
            rw_s1 <= rw;
            rw_s2 <= rw_s1;
        end
    end

    // addr/data are sampled raw; the bus holds them stable through this cycle
    assign commit  = ce_s3 & ~ce_s2 & ~rw_s2;
    assign ctrl_wr = commit & (addr == CTRL_A);
    assign wdata   = data[PWM_W:1];

    assign tick = (pre == PS_W'(PRESCALE - 1));
    assign wrap = tick & (&cnt);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (commit && addr == ADDR_W'(i))
                    shadow[i] <= wdata;
                if (wrap || force_q)
                    active[i] <= shadow[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            enable  <= 1'b1;
            invert  <= 1'b0;
            force_q <= 1'b0;
        end else begin
            force_q <= ctrl_wr & data[3];
            if (ctrl_wr) begin
                enable <= data[1];
                invert <= data[2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            leds <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                leds[i+1] <= (enable & ((cnt < active[i]) | (&active[i])))
                             ^ invert;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (addr == ADDR_W'(i))
                rdata = DATA_W'(shadow[i]);
        if (addr == CTRL_A)
            rdata = DATA_W'({invert, enable});
        if (addr == STAT_A)
            rdata = DATA_W'(cnt);
    end

    assign data = (reset_l && !ce_l && rw) ? rdata : 'z;

endmodule
